// File: rtl/flash_line_prefetcher_pkg.sv
// Shared types and helpers for the flash line prefetcher: FSM encoding and counter widths.
package flash_line_prefetcher_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned HITS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEM  = 2'd1,
    ST_PF   = 2'd2,
    ST_PF_Q = 2'd3
  } state_t;

  function automatic logic [HITS_W-1:0] sat_inc(input logic [HITS_W-1:0] v);
    return (&v) ? v : v + HITS_W'(1);
  endfunction

endpackage

// File: rtl/flash_line_prefetcher.sv
// Single-line sequential prefetch buffer between the flash cache controller and the QSPI line reader.
// After each demand fill the next line is fetched speculatively; a later demand for it is served from the buffer.
module flash_line_prefetcher
  import flash_line_prefetcher_pkg::*;
#(
  parameter int unsigned LINE_SIZE   = 128,
  parameter bit          PREFETCH_EN = 1'b1
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic                 req_rd,
  output logic                 req_done,
  output logic [LINE_SIZE-1:0] req_line,
  input  logic                 flush,
  output logic [ADDR_W-1:0]    fr_addr,
  output logic                 fr_rd,
  input  logic                 fr_done,
  input  logic [LINE_SIZE-1:0] fr_line,
  output logic [HITS_W-1:0]    pf_hits
);

  localparam int unsigned OFF   = $clog2(LINE_SIZE / 8);
  localparam int unsigned TAG_W = ADDR_W - OFF;

  state_t               state, state_nxt;
  logic [TAG_W-1:0]     cur_tag, req_tag, pf_tag, q_tag, issue_tag;
  logic [LINE_SIZE-1:0] pf_line;
  logic                 pf_valid, joined, discard;
  logic                 pf_valid_d, joined_d, discard_d;
  logic                 issue, serve, serve_buf, q_load, hit_inc;
  logic                 in_pf_any, drop, req_hit, pf_req, join_now, pf_serve, pf_redo, pf_store;
  logic                 unused_addr_lsb;

  // fr_addr keeps the address of the reader op in flight, so it doubles as the in-flight tag
  assign cur_tag   = fr_addr[ADDR_W-1:OFF];
  assign req_tag   = req_addr[ADDR_W-1:OFF];
  assign in_pf_any = (state == ST_PF) || (state == ST_PF_Q);
  assign drop      = discard | flush;
  assign req_hit   = (state == ST_IDLE) & req_rd & pf_valid & ~flush & (pf_tag == req_tag);
  assign pf_req    = (state == ST_PF) & req_rd & ~joined;
  assign join_now  = ~drop & (joined | (pf_req & (req_tag == cur_tag)));
  assign pf_serve  = (state == ST_PF) & fr_done & join_now;
  assign pf_redo   = (state == ST_PF) & fr_done & ~join_now & (joined | pf_req);
  assign pf_store  = PREFETCH_EN & in_pf_any & fr_done & ~drop;
  assign hit_inc   = serve & (serve_buf | (state == ST_PF));
  assign unused_addr_lsb = ^req_addr[OFF-1:0];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (req_rd) state_nxt = req_hit ? ST_PF : ST_DEM;
      ST_DEM:  if (fr_done) state_nxt = PREFETCH_EN ? ST_PF : ST_IDLE;
      ST_PF: begin
        if (fr_done) begin
          if (pf_serve)     state_nxt = ST_PF;
          else if (pf_redo) state_nxt = ST_DEM;
          else              state_nxt = ST_IDLE;
        end else if ((joined & flush) | (pf_req & ~join_now)) begin
          state_nxt = ST_PF_Q;
        end
      end
      ST_PF_Q: if (fr_done) state_nxt = ST_DEM;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-cycle actions: reader issue, demand completion, queue capture
  always_comb begin
    issue      = 1'b0;
    issue_tag  = cur_tag + TAG_W'(1);
    serve      = 1'b0;
    serve_buf  = 1'b0;
    q_load     = 1'b0;
    pf_valid_d = pf_store ? 1'b1 : (flush ? 1'b0 : pf_valid);
    joined_d   = (state == ST_PF) & ~fr_done & join_now;
    discard_d  = in_pf_any & ~fr_done & drop;
    unique case (state)
      ST_IDLE: begin
        if (req_rd) begin
          issue = 1'b1;
          if (req_hit) begin
            serve     = 1'b1;
            serve_buf = 1'b1;
            issue_tag = req_tag + TAG_W'(1);
          end else begin
            issue_tag = req_tag;
          end
        end
      end
      ST_DEM: begin
        if (fr_done) begin
          serve = 1'b1;
          issue = PREFETCH_EN;
        end
      end
      ST_PF: begin
        if (fr_done) begin
          if (pf_serve) begin
            serve = 1'b1;
            issue = 1'b1;
          end else if (pf_redo) begin
            issue     = 1'b1;
            issue_tag = pf_req ? req_tag : q_tag;
          end
        end else if (pf_req) begin
          q_load = 1'b1;
        end
      end
      ST_PF_Q: begin
        if (fr_done) begin
          issue     = 1'b1;
          issue_tag = q_tag;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fr_rd    <= 1'b0;
      fr_addr  <= '0;
      req_done <= 1'b0;
      req_line <= '0;
      pf_hits  <= '0;
      q_tag    <= '0;
      pf_tag   <= '0;
      pf_line  <= '0;
      pf_valid <= 1'b0;
      joined   <= 1'b0;
      discard  <= 1'b0;
    end else begin
      fr_rd    <= issue;
      req_done <= serve;
      pf_valid <= pf_valid_d;
      joined   <= joined_d;
      discard  <= discard_d;
      if (issue)   fr_addr  <= {issue_tag, {OFF{1'b0}}};
      if (serve)   req_line <= serve_buf ? pf_line : fr_line;
      if (hit_inc) pf_hits  <= sat_inc(pf_hits);
      if (q_load)  q_tag    <= req_tag;
      if (pf_store) begin
        pf_line <= fr_line;
        pf_tag  <= cur_tag;
      end
    end
  end

endmodule

// File: tb/tb_flash_line_prefetcher.sv
// Directed bench for flash_line_prefetcher: demand/hit/join/queue/wrap/flush/reset, plus a pass-through instance.
module tb_flash_line_prefetcher;

  localparam int unsigned LS  = 128;
  localparam int          LAT = 4;

  logic          HCLK, HRESETn;
  logic [23:0]   req_addr, fr_addr;
  logic          req_rd, req_done, flush, fr_rd, fr_done;
  logic [LS-1:0] req_line, fr_line;
  logic [15:0]   pf_hits;

  logic [23:0]   np_req_addr, np_fr_addr;
  logic          np_req_rd, np_req_done, np_flush, np_fr_rd, np_fr_done;
  logic [LS-1:0] np_req_line, np_fr_line;
  logic [15:0]   np_pf_hits;

  int n_vec = 0, n_err = 0;
  int cyc = 0, n_done = 0, n_frdone = 0, np_ndone = 0, np_nrd = 0;
  int t_done = 0, t_frdone = 0, t_req = 0, b2b = 0;
  logic prev_done = 1'b0;
  logic [23:0] fr_log[$];

  flash_line_prefetcher #(.LINE_SIZE(LS), .PREFETCH_EN(1'b1)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_addr(req_addr), .req_rd(req_rd),
    .req_done(req_done), .req_line(req_line), .flush(flush), .fr_addr(fr_addr),
    .fr_rd(fr_rd), .fr_done(fr_done), .fr_line(fr_line), .pf_hits(pf_hits)
  );

  flash_line_prefetcher #(.LINE_SIZE(LS), .PREFETCH_EN(1'b0)) u_np (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_addr(np_req_addr), .req_rd(np_req_rd),
    .req_done(np_req_done), .req_line(np_req_line), .flush(np_flush), .fr_addr(np_fr_addr),
    .fr_rd(np_fr_rd), .fr_done(np_fr_done), .fr_line(np_fr_line), .pf_hits(np_pf_hits)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic [LS-1:0] line_of(input logic [23:0] a);
    return {8'hA0, a, 8'h5B, ~a, 8'hC3, a ^ 24'h123456, 8'h7E, a + 24'd1};
  endfunction

  // Reader models: fixed latency, one op at a time
  logic busy, np_busy;
  int cnt, np_cnt;
  logic [23:0] rd_addr, np_rd_addr;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      busy <= 1'b0; cnt <= 0; fr_done <= 1'b0; fr_line <= '0; rd_addr <= '0;
    end else begin
      fr_done <= 1'b0;
      if (busy) begin
        if (cnt == 1) begin
          fr_done <= 1'b1; fr_line <= line_of(rd_addr); busy <= 1'b0;
        end else cnt <= cnt - 1;
      end else if (fr_rd) begin
        busy <= 1'b1; cnt <= LAT; rd_addr <= fr_addr;
      end
    end
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      np_busy <= 1'b0; np_cnt <= 0; np_fr_done <= 1'b0; np_fr_line <= '0; np_rd_addr <= '0;
    end else begin
      np_fr_done <= 1'b0;
      if (np_busy) begin
        if (np_cnt == 1) begin
          np_fr_done <= 1'b1; np_fr_line <= line_of(np_rd_addr); np_busy <= 1'b0;
        end else np_cnt <= np_cnt - 1;
      end else if (np_fr_rd) begin
        np_busy <= 1'b1; np_cnt <= LAT; np_rd_addr <= np_fr_addr;
      end
    end
  end

  always @(posedge HCLK) begin
    cyc <= cyc + 1;
    if (req_rd) t_req <= cyc;
    if (fr_done) begin n_frdone <= n_frdone + 1; t_frdone <= cyc; end
    if (req_done) begin
      n_done <= n_done + 1; t_done <= cyc;
      if (prev_done) b2b <= b2b + 1;
    end
    prev_done <= req_done;
    if (fr_rd) fr_log.push_back(fr_addr);
    if (np_req_done) np_ndone <= np_ndone + 1;
    if (np_fr_rd) np_nrd <= np_nrd + 1;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  function automatic int cnt_of(input int sel);
    case (sel)
      0:       return n_done;
      1:       return n_frdone;
      default: return np_ndone;
    endcase
  endfunction

  task automatic wait_cnt(input string tag, input int sel, input int target);
    for (int i = 0; i < 200 && cnt_of(sel) < target; i++) tick();
    chk(tag, 128'(cnt_of(sel)), 128'(target));
  endtask

  task automatic do_req(input logic [23:0] a);
    req_addr = a; req_rd = 1'b1; tick(); req_rd = 1'b0;
  endtask

  task automatic np_req(input logic [23:0] a);
    np_req_addr = a; np_req_rd = 1'b1; tick(); np_req_rd = 1'b0;
  endtask

  int ls, nd;

  initial begin
    HRESETn = 1'b0; req_addr = '0; req_rd = 1'b0; flush = 1'b0;
    np_req_addr = '0; np_req_rd = 1'b0; np_flush = 1'b0;
    repeat (3) tick();
    chk("rst_req_done", 128'(req_done), 128'(0));
    chk("rst_req_line", req_line, '0);
    chk("rst_fr_rd",    128'(fr_rd), 128'(0));
    chk("rst_fr_addr",  128'(fr_addr), 128'(0));
    chk("rst_pf_hits",  128'(pf_hits), 128'(0));
    HRESETn = 1'b1;
    tick();

    // Cold miss, then prefetch of the following line
    do_req(24'h000100);
    wait_cnt("cold_done", 0, 1);
    chk("cold_fr_addr", 128'(fr_log[0]), 128'(24'h000100));
    chk("cold_line", req_line, line_of(24'h000100));
    chk("cold_lat", 128'(t_done - t_frdone), 128'(1));
    wait_cnt("cold_pf_done", 1, 2);
    chk("cold_pf_addr", 128'(fr_log[1]), 128'(24'h000110));
    chk("cold_nrd", 128'(fr_log.size()), 128'(2));

    // Buffer hit
    do_req(24'h000110);
    wait_cnt("hit_done", 0, 2);
    chk("hit_lat", 128'(t_done - t_req), 128'(1));
    chk("hit_line", req_line, line_of(24'h000110));
    chk("hit_cnt", 128'(pf_hits), 128'(1));
    chk("hit_nrd", 128'(fr_log.size()), 128'(3));
    chk("hit_pf_addr", 128'(fr_log[2]), 128'(24'h000120));

    // Demand joins the prefetch in flight
    do_req(24'h000120);
    wait_cnt("join_done", 0, 3);
    chk("join_lat", 128'(t_done - t_frdone), 128'(1));
    chk("join_line", req_line, line_of(24'h000120));
    chk("join_cnt", 128'(pf_hits), 128'(2));
    chk("join_nrd", 128'(fr_log.size()), 128'(4));
    chk("join_pf_addr", 128'(fr_log[3]), 128'(24'h000130));

    // Non-matching demand queued behind prefetch of 0x130
    do_req(24'h004000);
    wait_cnt("q_done", 0, 4);
    chk("q_fr_addr", 128'(fr_log[4]), 128'(24'h004000));
    chk("q_line", req_line, line_of(24'h004000));
    chk("q_pf_addr", 128'(fr_log[5]), 128'(24'h004010));
    chk("q_cnt", 128'(pf_hits), 128'(2));
    wait_cnt("q_pf_done", 1, 6);

    // Top-of-space wrap, then flush discards the prefetch of line 0
    do_req(24'hFFFFF0);
    wait_cnt("wrap_done", 0, 5);
    chk("wrap_line", req_line, line_of(24'hFFFFF0));
    chk("wrap_pf_addr", 128'(fr_log[7]), 128'(24'h000000));
    flush = 1'b1; tick(); flush = 1'b0;
    wait_cnt("flush_pf_done", 1, 8);
    do_req(24'h000000);
    wait_cnt("flush_done", 0, 6);
    chk("flush_miss_addr", 128'(fr_log[8]), 128'(24'h000000));
    chk("flush_line", req_line, line_of(24'h000000));
    chk("flush_cnt", 128'(pf_hits), 128'(2));
    wait_cnt("flush_pf2_done", 1, 10);
    chk("flush_pf2_addr", 128'(fr_log[9]), 128'(24'h000010));

    // Reset while a demand is in the reader
    do_req(24'h000200);
    tick(); tick();
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_req_done", 128'(req_done), 128'(0));
    chk("mid_rst_req_line", req_line, '0);
    chk("mid_rst_fr_rd",    128'(fr_rd), 128'(0));
    chk("mid_rst_fr_addr",  128'(fr_addr), 128'(0));
    chk("mid_rst_pf_hits",  128'(pf_hits), 128'(0));
    tick();
    HRESETn = 1'b1;
    tick();
    ls = fr_log.size(); nd = n_done;
    do_req(24'h000300);
    wait_cnt("post_rst_done", 0, nd + 1);
    chk("post_rst_addr", 128'(fr_log[ls]), 128'(24'h000300));
    chk("post_rst_line", req_line, line_of(24'h000300));
    chk("post_rst_cnt", 128'(pf_hits), 128'(0));

    // Pass-through instance: no speculative reads
    np_req(24'h000500);
    wait_cnt("np_done1", 2, 1);
    chk("np_line1", np_req_line, line_of(24'h000500));
    repeat (12) tick();
    chk("np_nrd1", 128'(np_nrd), 128'(1));
    chk("np_cnt", 128'(np_pf_hits), 128'(0));
    np_req(24'h000510);
    wait_cnt("np_done2", 2, 2);
    chk("np_nrd2", 128'(np_nrd), 128'(2));
    chk("np_line2", np_req_line, line_of(24'h000510));

    chk("done_b2b", 128'(b2b), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
